// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG collector slice.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FULL    = 2'd3
    } trng_state_e;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_WARMUP_CYCLES = 256;
    localparam int DEF_RCT_LIMIT     = 32;

endpackage

// File: rtl/trng_vn_extractor.sv
// Von Neumann debiaser: pairs consecutive raw bits, 10 -> 1, 01 -> 0, 00/11 -> nothing.
module trng_vn_extractor (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic raw_bit,
    output logic bit_valid,
    output logic vn_bit
);

    logic phase_r;
    logic first_r;

    // Pair register and phase flag; clear forces the next sample to be a first bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
            first_r <= 1'b0;
        end else if (clear) begin
            phase_r <= 1'b0;
            first_r <= 1'b0;
        end else if (!phase_r) begin
            phase_r <= 1'b1;
            first_r <= raw_bit;
        end else begin
            phase_r <= 1'b0;
            first_r <= first_r;
        end
    end

    // A discordant pair emits its first bit.
    always_comb begin
        bit_valid = 1'b0;
        vn_bit    = first_r;
        if (!clear && phase_r && (first_r != raw_bit)) begin
            bit_valid = 1'b1;
        end else begin
            bit_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: warm-up, von Neumann debiasing, word packing with valid/ready,
// and a sticky repetition-count health test on the raw stream.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int RCT_LIMIT     = DEF_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             trng_en,
    input  logic             trng_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_data,
    output logic             health_err,
    input  logic             health_clr
);

    localparam int WU_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BC_W = $clog2(WIDTH + 1);
    localparam int RC_W = $clog2(RCT_LIMIT + 1);
    localparam logic [WU_W-1:0] WARM_LAST = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(WIDTH - 1);
    localparam logic [RC_W-1:0] RC_MAX    = RC_W'(RCT_LIMIT);

    trng_state_e      state_r, state_nx;
    logic [WU_W-1:0]  warm_cnt_r;
    logic [BC_W-1:0]  bit_cnt_r;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shift_nx_s;
    logic [RC_W-1:0]  run_r, run_nx_s;
    logic             last_r;
    logic             collect_s, active_s, trip_s;
    logic             bit_valid_s, vn_bit_s;

    assign collect_s  = (state_r == ST_COLLECT) && enable;
    assign active_s   = (state_r == ST_COLLECT) || (state_r == ST_FULL);
    assign shift_nx_s = {shreg_r[WIDTH-2:0], vn_bit_s};

    trng_vn_extractor u_vn (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!collect_s),
        .raw_bit   (trng_out),
        .bit_valid (bit_valid_s),
        .vn_bit    (vn_bit_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_nx = state_r;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nx = ST_WARMUP;
                ST_WARMUP:  state_nx = (warm_cnt_r == WARM_LAST) ? ST_COLLECT : ST_WARMUP;
                ST_COLLECT: state_nx = (bit_valid_s && (bit_cnt_r == BC_LAST)) ? ST_FULL : ST_COLLECT;
                ST_FULL:    state_nx = word_ready ? ST_COLLECT : ST_FULL;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // Warm-up counting, word packing and the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trng_en    <= 1'b0;
            warm_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else begin
            trng_en <= (state_nx != ST_IDLE);
            if (!enable) begin
                warm_cnt_r <= '0;
                bit_cnt_r  <= '0;
                shreg_r    <= '0;
                word_valid <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE:   warm_cnt_r <= '0;
                    ST_WARMUP: warm_cnt_r <= warm_cnt_r + WU_W'(1);
                    ST_COLLECT: begin
                        if (bit_valid_s) begin
                            shreg_r <= shift_nx_s;
                            if (bit_cnt_r == BC_LAST) begin
                                word_data  <= shift_nx_s;
                                word_valid <= 1'b1;
                                bit_cnt_r  <= '0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BC_W'(1);
                            end
                        end
                    end
                    ST_FULL: begin
                        if (word_ready) begin
                            word_valid <= 1'b0;
                        end
                    end
                    default: word_valid <= 1'b0;
                endcase
            end
        end
    end

    // Run length including the current raw bit, saturating at the limit.
    always_comb begin
        run_nx_s = run_r;
        if ((run_r == '0) || (trng_out != last_r)) begin
            run_nx_s = RC_W'(1);
        end else if (run_r == RC_MAX) begin
            run_nx_s = run_r;
        end else begin
            run_nx_s = run_r + RC_W'(1);
        end
        trip_s = active_s && (run_nx_s == RC_MAX);
    end

    // Repetition-count test; a trip in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r      <= '0;
            last_r     <= 1'b0;
            health_err <= 1'b0;
        end else begin
            if ((state_nx == ST_WARMUP) && (state_r != ST_WARMUP)) begin
                run_r <= '0;
            end else if (active_s) begin
                last_r <= trng_out;
                run_r  <= health_clr ? RC_W'(1) : run_nx_s;
            end else begin
                run_r <= run_r;
            end
            if (trip_s) begin
                health_err <= 1'b1;
            end else if (health_clr) begin
                health_err <= 1'b0;
            end else begin
                health_err <= health_err;
            end
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector with a scoreboard of expected words.
module tb_trng_collector;

    localparam int W   = 8;
    localparam int WU  = 4;
    localparam int RCT = 6;

    logic         clk = 1'b0;
    logic         rst_n, enable, trng_en, trng_out;
    logic         word_valid, word_ready, health_err, health_clr;
    logic [W-1:0] word_data;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_sh;
    int           m_cnt;
    logic         prev_wv = 1'b0;

    logic [1:0] w1 [10] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [1:0] w2 [10] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10};
    logic [1:0] w3 [8]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] w4 [8]  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    always #5 clk = ~clk;

    trng_collector #(.WIDTH(W), .WARMUP_CYCLES(WU), .RCT_LIMIT(RCT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .trng_en    (trng_en),
        .trng_out   (trng_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .health_err (health_err),
        .health_clr (health_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic clr);
        trng_out   = b;
        health_clr = clr;
        step();
        health_clr = 1'b0;
    endtask

    // Reference debiaser: a discordant pair contributes its first bit.
    task automatic feed_pair(input logic a, input logic b);
        if (a != b) begin
            m_sh = {m_sh[W-2:0], a};
            m_cnt++;
            if (m_cnt == W) begin
                exp_q.push_back(m_sh);
                m_cnt = 0;
            end
        end
        drive_bit(a, 1'b0);
        drive_bit(b, 1'b0);
    endtask

    task automatic warmup(input logic [3:0] pat);
        enable = 1'b1;
        step();
        check("trng_en_rise", {31'd0, trng_en}, 32'd1);
        for (int i = 0; i < WU; i++) begin
            trng_out = pat[i];
            step();
            check("warmup_no_word", {31'd0, word_valid}, 32'd0);
        end
    endtask

    // Scoreboard: each rising word_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (word_valid && !prev_wv) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_word observed=0x%0h expected=none", word_data);
            end else begin
                check("sb_word", {24'd0, word_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_wv = word_valid;
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; trng_out = 1'b0;
        word_ready = 1'b0; health_clr = 1'b0;
        m_sh = '0; m_cnt = 0;
        #2;
        check("rst_trng_en", {31'd0, trng_en}, 32'd0);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_data", {24'd0, word_data}, 32'd0);
        check("rst_health", {31'd0, health_err}, 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            trng_out = i[0];
            step();
            check("idle_trng_en", {31'd0, trng_en}, 32'd0);
        end

        // Word 1: 8'hB2, valid exactly after the final emitting pair.
        warmup(4'b0101);
        for (int i = 0; i < 10; i++) begin
            feed_pair(w1[i][1], w1[i][0]);
            check("w1_valid", {31'd0, word_valid}, (i == 9) ? 32'd1 : 32'd0);
        end

        // Backpressure: word held stable for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            trng_out = i[0];
            step();
            check("bp_valid", {31'd0, word_valid}, 32'd1);
            check("bp_data", {24'd0, word_data}, 32'hB2);
        end
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        check("accept_valid_low", {31'd0, word_valid}, 32'd0);

        // Word 2 with ready held high: one FULL cycle then accepted.
        word_ready = 1'b1;
        for (int i = 0; i < 10; i++) feed_pair(w2[i][1], w2[i][0]);
        check("w2_valid", {31'd0, word_valid}, 32'd1);
        check("w2_data", {24'd0, word_data}, 32'h2D);
        step();
        check("w2_accept", {31'd0, word_valid}, 32'd0);
        word_ready = 1'b0;

        // Health: six equal bits trip, flag is sticky, clear works, set beats clear.
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        check("rct_below", {31'd0, health_err}, 32'd0);
        drive_bit(1'b1, 1'b0);
        check("rct_trip", {31'd0, health_err}, 32'd1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        check("rct_sticky", {31'd0, health_err}, 32'd1);
        drive_bit(1'b0, 1'b1);
        check("rct_clear", {31'd0, health_err}, 32'd0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        check("rct_run5", {31'd0, health_err}, 32'd0);
        drive_bit(1'b0, 1'b1);
        check("rct_set_wins", {31'd0, health_err}, 32'd1);

        // Word 3 collected despite the error, then lost on disable.
        for (int i = 0; i < 8; i++) feed_pair(w3[i][1], w3[i][0]);
        check("w3_valid", {31'd0, word_valid}, 32'd1);
        check("w3_health", {31'd0, health_err}, 32'd1);
        enable = 1'b0;
        step();
        check("dis_valid", {31'd0, word_valid}, 32'd0);
        check("dis_trng_en", {31'd0, trng_en}, 32'd0);
        m_cnt = 0;
        m_sh  = '0;
        step();
        step();

        // Re-enable: warm-up repeats, word 4 built from fresh bits only.
        warmup(4'b1010);
        for (int i = 0; i < 8; i++) feed_pair(w4[i][1], w4[i][0]);
        check("w4_valid", {31'd0, word_valid}, 32'd1);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        check("w4_accept", {31'd0, word_valid}, 32'd0);
        check("w4_hold", {24'd0, word_data}, 32'h55);
        step();
        check("w4_hold2", {24'd0, word_data}, 32'h55);

        // Asynchronous reset in the middle of COLLECT.
        feed_pair(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_trng_en", {31'd0, trng_en}, 32'd0);
        check("arst_valid", {31'd0, word_valid}, 32'd0);
        check("arst_data", {24'd0, word_data}, 32'd0);
        check("arst_health", {31'd0, health_err}, 32'd0);
        #5;
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", {31'd0, trng_en}, 32'd0);
        end
        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
